// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one request at a time, drives a downstream
// combinational ALU for a per-opcode number of cycles, captures the result,
// updates the architectural HI/LO pair for div/mul, and holds a response
// until the consumer takes it.
module alu_op_sequencer #(
  parameter int unsigned SIMPLE_LAT = 1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_out2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic [3:0]  rsp_op,
  output logic        rsp_err,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;

  // Counter preloads: the EXEC state lasts LAT cycles, counting LAT-1 down to 0.
  localparam logic [3:0] SIMPLE_CNT = 4'(SIMPLE_LAT - 1);
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT - 1);

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

  // Divide-by-zero is rejected up front so the ALU never sees it.
  function automatic logic is_legal(input logic [3:0] op, input logic [31:0] b);
    return (op >= 4'd1) && (op <= 4'd11) && !((op == OP_DIV) && (b == '0));
  endfunction

  state_t      state_q,  state_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [3:0]  op_q,     op_d;
  logic [31:0] rsp_lo_q, rsp_lo_d;
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] hi_q,     hi_d;
  logic [31:0] lo_q,     lo_d;

  // Next-state and datapath update for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rsp_lo_d  = rsp_lo_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_err_d = rsp_err_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          if (is_legal(req_op, req_b)) begin
            state_d = EXEC;
            cnt_d   = is_muldiv(req_op) ? MULDIV_CNT : SIMPLE_CNT;
          end else begin
            state_d   = DONE;
            cnt_d     = '0;
            rsp_lo_d  = '0;
            rsp_hi_d  = '0;
            rsp_err_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = DONE;
          rsp_lo_d  = alu_out;
          rsp_hi_d  = is_muldiv(op_q) ? alu_out2 : '0;
          rsp_err_d = 1'b0;
          if (is_muldiv(op_q)) begin
            lo_d = alu_out;
            hi_d = alu_out2;
          end
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_lo_q  <= '0;
      rsp_hi_q  <= '0;
      rsp_err_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_err_q <= rsp_err_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Output decode; req_ready is gated by reset_n so it stays low during reset.
  always_comb begin
    req_ready = (state_q == IDLE) && reset_n;
    rsp_valid = (state_q == DONE);
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = (state_q == EXEC) ? op_q : 4'b0000;
    rsp_lo    = rsp_lo_q;
    rsp_hi    = rsp_hi_q;
    rsp_op    = op_q;
    rsp_err   = rsp_err_q;
    hi_reg    = hi_q;
    lo_reg    = lo_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out, alu_out2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic [3:0]  rsp_op;
  logic        rsp_err;
  logic [31:0] hi_reg, lo_reg;

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_sequencer #(.SIMPLE_LAT(1), .MULDIV_LAT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_out2(alu_out2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  always #5 clock = ~clock;

  // Downstream combinational ALU: div gives quotient/remainder, mul gives 64-bit product.
  logic [63:0] prod;
  always_comb begin
    prod     = 64'(alu_a) * 64'(alu_b);
    alu_out  = 32'hDEADBEEF;
    alu_out2 = 32'hDEADBEEF;
    case (alu_op)
      4'd1: alu_out = alu_a + alu_b;
      4'd2: alu_out = alu_a - alu_b;
      4'd3: if (alu_b != 0) begin alu_out = alu_a / alu_b; alu_out2 = alu_a % alu_b; end
      4'd4: begin alu_out = prod[31:0]; alu_out2 = prod[63:32]; end
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request on an IDLE sequencer and pass the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Clock until rsp_valid (bounded); reports edges taken and cycles alu_op==op.
  task automatic run_to_done(input logic [3:0] op, output int edges, output int op_cycles);
    edges = 0; op_cycles = 0;
    while (!rsp_valid && edges < 20) begin
      if (alu_op == op) op_cycles++;
      tick();
      edges++;
    end
  endtask

  int edges, opc, seen;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_lo_reg", lo_reg, 0);
    check("rst_rsp_lo", rsp_lo, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(req_ready), 1);

    // ADD 5+7
    send(4'd1, 32'd5, 32'd7);
    check("add_ready_low", 32'(req_ready), 0);
    check("add_alu_op", 32'(alu_op), 1);
    run_to_done(4'd1, edges, opc);
    check("add_edges", edges, 1);
    check("add_lo", rsp_lo, 12);
    check("add_hi", rsp_hi, 0);
    check("add_err", 32'(rsp_err), 0);
    check("add_rsp_op", 32'(rsp_op), 1);
    check("add_lo_reg", lo_reg, 0);
    tick();
    check("add_back_idle", 32'(req_ready), 1);

    // MUL 6*7
    send(4'd4, 32'd6, 32'd7);
    run_to_done(4'd4, edges, opc);
    check("mul_edges", edges, 4);
    check("mul_op_cycles", opc, 4);
    check("mul_lo", rsp_lo, 42);
    check("mul_hi", rsp_hi, 0);
    check("mul_lo_reg", lo_reg, 42);
    check("mul_hi_reg", hi_reg, 0);
    tick();

    // MUL with nonzero high word: 0x10000 * 0x30000 = 0x3_0000_0000
    send(4'd4, 32'h10000, 32'h30000);
    run_to_done(4'd4, edges, opc);
    check("mul2_lo", rsp_lo, 0);
    check("mul2_hi", rsp_hi, 3);
    check("mul2_hi_reg", hi_reg, 3);
    tick();

    // DIV 100/7
    send(4'd3, 32'd100, 32'd7);
    run_to_done(4'd3, edges, opc);
    check("div_edges", edges, 4);
    check("div_lo", rsp_lo, 14);
    check("div_hi", rsp_hi, 2);
    check("div_err", 32'(rsp_err), 0);
    check("div_lo_reg", lo_reg, 14);
    check("div_hi_reg", hi_reg, 2);
    tick();

    // Divide by zero: straight to DONE
    send(4'd3, 32'd100, 32'd0);
    check("dz_valid", 32'(rsp_valid), 1);
    check("dz_err", 32'(rsp_err), 1);
    check("dz_lo", rsp_lo, 0);
    check("dz_hi", rsp_hi, 0);
    check("dz_alu_op", 32'(alu_op), 0);
    check("dz_lo_reg", lo_reg, 14);
    check("dz_hi_reg", hi_reg, 2);
    tick();

    // Illegal opcode 15
    send(4'hF, 32'd1, 32'd2);
    check("ill_valid", 32'(rsp_valid), 1);
    check("ill_err", 32'(rsp_err), 1);
    check("ill_lo", rsp_lo, 0);
    check("ill_alu_op", 32'(alu_op), 0);
    check("ill_rsp_op", 32'(rsp_op), 15);
    check("ill_hi_reg", hi_reg, 2);
    tick();

    // Backpressure: SUB 10-3 held in DONE while another request waits
    rsp_ready = 1'b0;
    send(4'd2, 32'd10, 32'd3);
    run_to_done(4'd2, edges, opc);
    check("bp_edges", edges, 1);
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_ready_low", 32'(req_ready), 0);
      check("bp_lo", rsp_lo, 7);
      check("bp_rsp_op", 32'(rsp_op), 2);
      check("bp_alu_a", alu_a, 10);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 0);
    check("bp_release_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    check("bp_next_accept", 32'(alu_op), 1);
    check("bp_next_alu_a", alu_a, 1);
    tick();
    check("bp_next_lo", rsp_lo, 2);
    tick();

    // Reset during EXEC of a MUL
    send(4'd4, 32'd6, 32'd7);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_alu_op", 32'(alu_op), 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_lo_reg", lo_reg, 0);
    check("mid_rst_hi_reg", hi_reg, 0);
    check("mid_rst_rsp_lo", rsp_lo, 0);
    check("mid_rst_rsp_op", 32'(rsp_op), 0);
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("post_rst_no_rsp", seen, 0);
    check("post_rst_ready2", 32'(req_ready), 1);
    check("post_rst_lo_reg", lo_reg, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SIMPLE_LAT, default 1: number of EXEC cycles for ops 1,2,5..11 (legal range 1..15).
REQ-002 SHALL have parameter MULDIV_LAT, default 4: number of EXEC cycles for ops 3 (div) and 4 (mul) (legal range 1..15).
REQ-003 SHALL provide clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL provide req_valid  in  1, req_ready  out  1: request handshake.
REQ-006 SHALL provide req_op  in  4, req_a  in  32, req_b  in  32: opcode (ALU encoding 1..11) and operands.
REQ-007 SHALL provide alu_a  out  32, alu_b  out  32, alu_op  out  4: drive the downstream combinational ALU.
REQ-008 SHALL provide alu_out  in  32, alu_out2  in  32: ALU low/primary and high/secondary results.
REQ-009 SHALL provide rsp_valid  out  1, rsp_ready  in  1: response handshake.
REQ-010 SHALL provide rsp_lo  out  32, rsp_hi  out  32, rsp_op  out  4, rsp_err  out  1: response payload.
REQ-011 SHALL provide hi_reg  out  32, lo_reg  out  32: architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-013 IDLE: on req_valid&req_ready SHALL latch req_a, req_b, req_op into operand registers and rsp_op.
REQ-014 On accept with legal op (1..11, excluding div with req_b==0) SHALL enter EXEC with counter=LAT-1 (LAT per REQ-001/002).
REQ-015 On accept with illegal op (0, 12..15) or op 3 with req_b==0 SHALL go directly to DONE with rsp_err=1, rsp_lo=0, rsp_hi=0, no ALU drive, no HI/LO update.
REQ-016 alu_a/alu_b SHALL equal latched operands at all times; alu_op SHALL equal latched op in EXEC and 4'b0000 otherwise.
REQ-017 EXEC: counter!=0 -> decrement, stay; counter==0 -> capture and go DONE on the same edge.
REQ-018 Capture: rsp_lo<=alu_out; rsp_hi<=alu_out2 for ops 3/4, else 0 (alu_out2 undefined for other ops); rsp_err<=0.
REQ-019 Capture of op 3 or 4 SHALL also load lo_reg<=alu_out, hi_reg<=alu_out2; other ops SHALL leave HI/LO unchanged.
REQ-020 Latency: request accepted at edge k -> state DONE after edge k+LAT; error path -> DONE after edge k.
REQ-021 DONE: payload SHALL hold stable while rsp_ready=0; on rsp_ready=1 SHALL return to IDLE at that edge; new request not accepted in same cycle (max 1 op in flight).
REQ-022 req_valid in EXEC/DONE SHALL be ignored (not latched); upstream holds it until req_ready.
REQ-023 Counter SHALL be 4 bits; no wrap; EXEC never exceeds LAT cycles.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state IDLE, counter 0, operand regs 0, alu_op 0, rsp_lo/rsp_hi/hi_reg/lo_reg 0, rsp_op 0, rsp_err 0, rsp_valid 0, req_ready deasserted while reset_n=0 and 1 after release.
REQ-025 Reset mid-EXEC or mid-DONE SHALL abort the op with no HI/LO update and no response.

Verification
REQ-026 ADD: op=1, a=5, b=7, SIMPLE_LAT=1, rsp_ready=1 -> rsp_valid one cycle after accept edge+1, rsp_lo=12, rsp_hi=0, rsp_err=0, HI/LO unchanged.
REQ-027 MUL: op=4, a=6, b=7, MULDIV_LAT=4 -> alu_op=4 for exactly 4 cycles, rsp_valid after edge k+4, rsp_lo=lo_reg=alu_out, rsp_hi=hi_reg=alu_out2.
REQ-028 DIV: op=3, a=100, b=7 -> rsp_lo=lo_reg=14, rsp_hi=hi_reg=2, rsp_err=0.
REQ-029 Errors: op=3, b=0 and op=4'b1111 -> DONE after accept edge, rsp_err=1, rsp_lo=rsp_hi=0, alu_op stays 0, HI/LO unchanged.
REQ-030 Backpressure: rsp_ready=0 for 3 cycles in DONE with req_valid=1 -> payload stable, req_ready=0, no second accept; rsp_ready=1 -> IDLE, next request accepted following cycle.
REQ-031 Reset mid-op: MUL accepted, reset_n=0 at EXEC cycle 2 -> all outputs 0 immediately, hi_reg/lo_reg=0, no rsp_valid after release.
